// File: rtl/equalizer_div_pkg.sv
// Shared widths, saturation limits, FSM encoding and magnitude helper for the equalizer divider.
package equalizer_div_pkg;

    localparam int DIVIDEND_W = 28;
    localparam int DIVISOR_W  = 16;
    localparam int QUOT_W     = 13;
    localparam int CNT_W      = 4;

    localparam logic signed [QUOT_W-1:0] QMAX = QUOT_W'((2 ** (QUOT_W-1)) - 1);
    localparam logic signed [QUOT_W-1:0] QMIN = QUOT_W'(-(2 ** (QUOT_W-1)));

    // Largest magnitudes representable for a positive / negative quotient.
    localparam logic [QUOT_W-1:0] MAG_POS = QUOT_W'((2 ** (QUOT_W-1)) - 1);
    localparam logic [QUOT_W-1:0] MAG_NEG = QUOT_W'(2 ** (QUOT_W-1));

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // -2^27 maps to 2^27, which still fits the unsigned result.
    function automatic logic [DIVIDEND_W-1:0] abs_u(input logic signed [DIVIDEND_W-1:0] x);
        abs_u = x[DIVIDEND_W-1] ? DIVIDEND_W'(-x) : DIVIDEND_W'(x);
    endfunction

endpackage

// File: rtl/equalizer_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor if it fits.
// Purely combinational; no latency, no flow control.
// The caller guarantees r_in < d, so the shifted remainder fits DIVISOR_W+1 bits.
module equalizer_div_step
    import equalizer_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] r_in,
    input  logic [DIVISOR_W-1:0] d,
    input  logic                 bit_in,
    output logic [DIVISOR_W-1:0] r_out,
    output logic                 qbit
);

    logic [DIVISOR_W:0] shifted;

    always_comb begin
        shifted = {r_in, bit_in};
        qbit    = (shifted >= {1'b0, d});
        r_out   = qbit ? DIVISOR_W'(shifted - {1'b0, d}) : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/equalizer_div_28s_16s_13.sv
// Iterative signed 28s/16s divider with saturated 13s quotient; EQUALIZER_DIV_REM_EN adds rem output.
// Latency: result valid 14 ce-cycles after accept (13 steps + 1 format cycle), fixed.
// Backpressure: one operation in flight; in_ready low until the result is taken; ce=0 freezes everything.
module equalizer_div_28s_16s_13
    import equalizer_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [QUOT_W-1:0]     dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf,
    output logic                  dbz
`ifdef EQUALIZER_DIV_REM_EN
    ,
    output logic [DIVISOR_W-1:0]  rem
`endif
);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [QUOT_W-1:0]      dvd_q;
    logic [DIVISOR_W-1:0]   r_q;
    logic [DIVISOR_W-1:0]   d_q;
    logic [QUOT_W-1:0]      quo_q;
    logic                   qsign_q, rsign_q, ovf_i_q, dbz_i_q;
    logic                   out_valid_q, ovf_q, dbz_q;
    logic [QUOT_W-1:0]      dout_q;

    logic [DIVIDEND_W-1:0]  a_abs;
    logic [DIVISOR_W-1:0]   d_abs;
    logic                   ovf_pre;
    logic [DIVISOR_W-1:0]   step_r;
    logic                   step_q;
    logic [QUOT_W-1:0]      fmt_dout;
    logic                   fmt_ovf;

    assign a_abs   = abs_u(din0);
    assign d_abs   = DIVISOR_W'(abs_u(DIVIDEND_W'($signed(din1))));
    // Quotient cannot fit QUOT_W magnitude bits; also true for a zero divisor.
    assign ovf_pre = ({1'b0, a_abs} >= {d_abs, {QUOT_W{1'b0}}});

    equalizer_div_step u_step (
        .r_in   (r_q),
        .d      (d_q),
        .bit_in (dvd_q[QUOT_W-1]),
        .r_out  (step_r),
        .qbit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ce && in_valid) state_d = CALC;
            CALC:    if (ce && cnt_q == '0) state_d = DONE;
            DONE:    if (ce && out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        fmt_dout = '0;
        fmt_ovf  = 1'b0;
        if (dbz_i_q) begin
            fmt_dout = rsign_q ? QMIN : QMAX;
            fmt_ovf  = 1'b1;
        end else if (ovf_i_q) begin
            fmt_dout = qsign_q ? QMIN : QMAX;
            fmt_ovf  = 1'b1;
        end else if (!qsign_q) begin
            fmt_ovf  = (quo_q > MAG_POS);
            fmt_dout = fmt_ovf ? QMAX : quo_q;
        end else begin
            // Negating a zero magnitude yields 0, so -0 never appears.
            fmt_ovf  = (quo_q > MAG_NEG);
            fmt_dout = fmt_ovf ? QMIN : QUOT_W'(-quo_q);
        end
    end

`ifdef EQUALIZER_DIV_REM_EN
    logic [DIVISOR_W-1:0] fmt_rem, rem_q;

    always_comb begin
        fmt_rem = '0;
        if (!fmt_ovf) fmt_rem = rsign_q ? DIVISOR_W'(-r_q) : r_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rem_q <= '0;
        else if (ce && state_q == DONE && !out_valid_q)
            rem_q <= fmt_rem;
    end

    assign rem = rem_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            r_q         <= '0;
            d_q         <= '0;
            quo_q       <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            ovf_i_q     <= 1'b0;
            dbz_i_q     <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // High dividend bits preload the remainder; low bits stream in per step.
                        r_q     <= DIVISOR_W'(a_abs[DIVIDEND_W-1:QUOT_W]);
                        dvd_q   <= a_abs[QUOT_W-1:0];
                        d_q     <= d_abs;
                        quo_q   <= '0;
                        qsign_q <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                        rsign_q <= din0[DIVIDEND_W-1];
                        ovf_i_q <= ovf_pre;
                        dbz_i_q <= (din1 == '0);
                        cnt_q   <= CNT_W'(QUOT_W-1);
                    end
                end
                CALC: begin
                    r_q   <= step_r;
                    quo_q <= {quo_q[QUOT_W-2:0], step_q};
                    dvd_q <= {dvd_q[QUOT_W-2:0], 1'b0};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        dout_q      <= fmt_dout;
                        ovf_q       <= fmt_ovf;
                        dbz_q       <= dbz_i_q;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_equalizer_div_28s_16s_13.sv
// Scoreboard bench: directed corner cases plus randomized operands against an integer-division model.
module tb_equalizer_div_28s_16s_13;

    typedef struct {
        logic signed [12:0] q;
        logic               ovf;
        logic               dbz;
        logic signed [15:0] rem;
    } exp_t;

    logic        clk, reset_n, ce, in_valid, in_ready, out_valid, out_ready, ovf, dbz;
    logic [27:0] din0;
    logic [15:0] din1;
    logic [12:0] dout;
`ifdef EQUALIZER_DIV_REM_EN
    logic [15:0] rem;
`endif

    equalizer_div_28s_16s_13 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .din0      (din0),
        .din1      (din1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .dbz       (dbz)
`ifdef EQUALIZER_DIV_REM_EN
        ,
        .rem       (rem)
`endif
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    logic ce_rand     = 1'b0;
    logic ordy_rand   = 1'b0;
    logic ordy_manual = 1'b0;
    logic ordy_val    = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer division (truncates toward zero), then clamp to 13-bit signed.
    function automatic exp_t model(input logic signed [27:0] a, input logic signed [15:0] b);
        exp_t   e;
        longint la, lb, q, r;
        la    = a;
        lb    = b;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        e.rem = '0;
        if (lb == 0) begin
            e.dbz = 1'b1;
            e.ovf = 1'b1;
            e.q   = (la < 0) ? -13'sd4095 - 13'sd1 : 13'sd4095;
        end else begin
            q = la / lb;
            r = la % lb;
            if (q > 4095) begin
                q = 4095;  e.ovf = 1'b1;
            end else if (q < -4096) begin
                q = -4096; e.ovf = 1'b1;
            end else begin
                e.rem = 16'(r);
            end
            e.q = 13'(q);
        end
        return e;
    endfunction

    // ce / out_ready are changed just after each rising edge.
    initial begin
        ce        = 1'b1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce        = ce_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = ordy_manual ? ordy_val : (ordy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: handshake tracking, fixed-latency check and scoreboard comparison.
    int   acc_cyc   = 0;
    logic lat_armed = 1'b0;
    logic ce_clean  = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            lat_armed = 1'b0;
        end else begin
            chk("in_ready_busy", {63'd0, in_ready}, {63'd0, exp_q.size() == 0});
            if (lat_armed) begin
                if (out_valid) begin
                    if (ce_clean) chk("latency", cyc - acc_cyc, 14);
                    lat_armed = 1'b0;
                end else if (!ce) begin
                    ce_clean = 1'b0;
                end
            end
            if (in_valid && in_ready && ce) begin
                acc_cyc   = cyc + 1;
                lat_armed = 1'b1;
                ce_clean  = 1'b1;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_unexpected", {63'd0, out_valid}, 0);
                end else begin
                    chk("dout", $signed(dout), exp_q[0].q);
                    chk("ovf", {63'd0, ovf}, {63'd0, exp_q[0].ovf});
                    chk("dbz", {63'd0, dbz}, {63'd0, exp_q[0].dbz});
`ifdef EQUALIZER_DIV_REM_EN
                    chk("rem", $signed(rem), exp_q[0].rem);
`endif
                    if (out_ready && ce) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Hold operands until accepted, then record the expected result.
    task automatic issue(input logic [27:0] a, input logic [15:0] b);
        logic acc;
        int   n;
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 600) begin
            @(negedge clk);
            acc = in_ready && ce && reset_n;
            @(posedge clk);
            #2;
            n++;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back(model(a, b));
        else     chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic rand_pair(output logic [27:0] a, output logic [15:0] b);
        int bs, babs, q, rr;
        case ($urandom_range(0, 3))
            0: begin
                a = 28'($urandom);
                b = 16'($urandom);
            end
            1: begin
                b = 16'($urandom);
                if (b == '0) b = 16'd1;
                bs   = int'($signed(b));
                babs = (bs < 0) ? -bs : bs;
                q    = int'($urandom_range(0, 8400)) - 4200;
                rr   = int'($urandom_range(0, 32'(babs - 1)));
                if ($urandom_range(0, 1) == 1) rr = -rr;
                a = 28'(longint'(q) * longint'(bs) + longint'(rr));
            end
            2: begin
                b = 16'($urandom_range(0, 40)) - 16'd20;
                a = 28'($urandom_range(0, 200000)) - 28'd100000;
            end
            default: begin
                b = 16'($urandom_range(0, 3)) - 16'd1;
                a = 28'($urandom);
            end
        endcase
    endtask

    initial begin
        logic [27:0] ra;
        logic [15:0] rb;
        int          n;

        reset_n  = 1'b1;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 1);
        chk("rst_out_valid", {63'd0, out_valid}, 0);
        chk("rst_dout", $signed(dout), 0);
        chk("rst_ovf", {63'd0, ovf}, 0);
        chk("rst_dbz", {63'd0, dbz}, 0);
`ifdef EQUALIZER_DIV_REM_EN
        chk("rst_rem", $signed(rem), 0);
`endif
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #2;

        // Directed corners with ce and out_ready held high.
        issue(28'd1000, 16'd10);
        issue(-28'sd1001, 16'd10);
        issue(28'd1 << 20, 16'd1);
        issue(-(28'sd1 <<< 20), 16'd1);
        issue(28'd5, 16'd0);
        issue(-28'sd5, 16'd0);
        issue(28'd0, 16'd7);
        issue(28'd0, -16'sd7);
        issue(-28'sd5, 16'd100);
        issue(28'h8000000, 16'h8000);
        issue(28'h8000000, 16'd1);
        issue(28'h7FFFFFF, -16'sd1);
        issue(28'h8000000, 16'h7FFF);
        issue(-28'sd12288, 16'd3);
        issue(28'd12288, -16'sd3);
        issue(28'd12285, 16'd3);
        drain();

        // ce toggling during the calculation must not change the answer.
        ce_rand = 1'b1;
        issue(28'd1000, 16'd10);
        issue(-28'sd1001, 16'd10);
        issue(28'd123456, -16'sd77);
        drain();
        ce_rand = 1'b0;

        // Result held with out_ready low: monitor compares it on every valid cycle.
        ordy_manual = 1'b1;
        ordy_val    = 1'b0;
        issue(28'd777, -16'sd3);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_seen", {63'd0, out_valid}, 1);
        repeat (3) @(posedge clk);
        #2 ordy_val = 1'b1;
        drain();
        ordy_manual = 1'b0;

        // Reset mid-calculation discards the operation immediately.
        issue(28'd5000, 16'd7);
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 0);
        chk("midrst_in_ready", {63'd0, in_ready}, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #2;
        issue(28'd5000, 16'd7);
        issue(-28'sd99999, 16'd33);
        drain();

        // Random operands; flow-control randomization enabled for the second half.
        for (int i = 0; i < 1200; i++) begin
            if (i == 600) begin
                ce_rand   = 1'b1;
                ordy_rand = 1'b1;
            end
            rand_pair(ra, rb);
            issue(ra, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
